fft1024_bfly_sequencer: RTL and testbench

- Control stage directly upstream of the FFT1024 twiddle LUT; the LUT is combinational (10-bit index n in, 32-bit {real, imag} twiddle out, Q1.15 each).
- On Start, walks all 10 radix-2 DIT stages × 512 butterflies of the in-place 1024-point FFT and drives n to the LUT.
- Captures the returned twiddle and issues one butterfly command per handshake to the downstream butterfly/RAM datapath.

---
 rtl/fft1024_bfly_sequencer_if.sv | 43 ++++
 rtl/fft1024_bfly_sequencer.sv | 149 ++++++++++++++
 tb/tb_fft1024_bfly_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fft1024_bfly_sequencer_if.sv
// Butterfly command bus between the FFT1024 sequencer, its twiddle LUT and the
// downstream butterfly/RAM datapath.
interface fft1024_bfly_sequencer_if #(
    parameter int LOG2N = 10,
    parameter int TW_W  = 16
);
    logic [LOG2N-1:0]  tw_addr;
    logic [2*TW_W-1:0] twiddle;
    logic              bf_valid;
    logic              bf_ready;
    logic [LOG2N-1:0]  bf_addr_a;
    logic [LOG2N-1:0]  bf_addr_b;
    logic [2*TW_W-1:0] bf_twiddle;
    logic [3:0]        bf_stage;
    logic              bf_last_in_stage;
    logic              bf_last;

    modport master (
        output tw_addr,
        input  twiddle,
        output bf_valid,
        input  bf_ready,
        output bf_addr_a,
        output bf_addr_b,
        output bf_twiddle,
        output bf_stage,
        output bf_last_in_stage,
        output bf_last
    );

    modport slave (
        input  tw_addr,
        output twiddle,
        input  bf_valid,
        output bf_ready,
        input  bf_addr_a,
        input  bf_addr_b,
        input  bf_twiddle,
        input  bf_stage,
        input  bf_last_in_stage,
        input  bf_last
    );
endinterface

// File: rtl/fft1024_bfly_sequencer.sv
// Walks every radix-2 DIT stage/butterfly of an in-place 1024-point FFT, looks up
// the twiddle and issues one valid/ready butterfly command per handshake.
module fft1024_bfly_sequencer #(
    parameter int LOG2N = 10,
    parameter int TW_W  = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_busy,
    output logic o_done,
    fft1024_bfly_sequencer_if.master io_bf
);
    localparam int K_W = LOG2N - 1;
    localparam int S_W = 4;
    localparam logic [K_W-1:0] K_LAST = '1;
    localparam logic [S_W-1:0] S_LAST = S_W'(LOG2N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [S_W-1:0] r_s;
    logic [K_W-1:0] r_k;

    logic              r_bf_valid;
    logic [LOG2N-1:0]  r_addr_a;
    logic [LOG2N-1:0]  r_addr_b;
    logic [2*TW_W-1:0] r_twiddle;
    logic [S_W-1:0]    r_stage;
    logic              r_last_in_stage;
    logic              r_last;
    logic              r_done;

    logic [LOG2N-1:0] w_k_ext;
    logic [LOG2N-1:0] w_span;
    logic [LOG2N-1:0] w_group;
    logic [LOG2N-1:0] w_pos;
    logic [LOG2N-1:0] w_addr_a;
    logic [LOG2N-1:0] w_addr_b;
    logic [LOG2N-1:0] w_tw_addr;
    logic             w_k_end;
    logic             w_all_end;
    logic             w_hs;
    logic             w_load;

    // Butterfly k of stage s pairs a and a+span inside group k>>s; its twiddle
    // exponent is pos scaled up to the full 1024-point circle.
    assign w_k_ext   = LOG2N'(r_k);
    assign w_span    = LOG2N'(1) << r_s;
    assign w_group   = w_k_ext >> r_s;
    assign w_pos     = w_k_ext & (w_span - LOG2N'(1));
    assign w_addr_a  = (w_group << (r_s + S_W'(1))) | w_pos;
    assign w_addr_b  = w_addr_a + w_span;
    assign w_tw_addr = (r_state == ST_IDLE) ? '0 : (w_pos << (S_LAST - r_s));

    assign w_k_end   = (r_k == K_LAST);
    assign w_all_end = w_k_end && (r_s == S_LAST);
    assign w_hs      = r_bf_valid && io_bf.bf_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no branch can infer a latch.
        w_state_nxt = r_state;
        w_load      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_load = !r_bf_valid || io_bf.bf_ready;
                if (w_load && w_all_end) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_hs) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s <= '0;
            r_k <= '0;
        end else if (w_load) begin
            if (w_all_end) begin
                r_s <= '0;
                r_k <= '0;
            end else if (w_k_end) begin
                r_s <= r_s + S_W'(1);
                r_k <= '0;
            end else begin
                r_k <= r_k + K_W'(1);
            end
        end
    end

    // Command register: fields change only on a load, so a stalled command holds.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bf_valid      <= 1'b0;
            r_addr_a        <= '0;
            r_addr_b        <= '0;
            r_twiddle       <= '0;
            r_stage         <= '0;
            r_last_in_stage <= 1'b0;
            r_last          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DRAIN) && w_hs;
            if (w_load) begin
                r_bf_valid      <= 1'b1;
                r_addr_a        <= w_addr_a;
                r_addr_b        <= w_addr_b;
                r_twiddle       <= io_bf.twiddle;
                r_stage         <= r_s;
                r_last_in_stage <= w_k_end;
                r_last          <= w_all_end;
            end else if (w_hs) begin
                r_bf_valid <= 1'b0;
            end
        end
    end

    assign o_busy                 = (r_state != ST_IDLE);
    assign o_done                 = r_done;
    assign io_bf.tw_addr          = w_tw_addr;
    assign io_bf.bf_valid         = r_bf_valid;
    assign io_bf.bf_addr_a        = r_addr_a;
    assign io_bf.bf_addr_b        = r_addr_b;
    assign io_bf.bf_twiddle       = r_twiddle;
    assign io_bf.bf_stage         = r_stage;
    assign io_bf.bf_last_in_stage = r_last_in_stage;
    assign io_bf.bf_last          = r_last;

endmodule

// File: tb/tb_fft1024_bfly_sequencer.sv
// Directed bench for fft1024_bfly_sequencer: full transforms under several
// bf_ready patterns, start/reset corner cases, and hand-computed spot checks.
module tb_fft1024_bfly_sequencer;
    localparam int LOG2N = 10;
    localparam int TW_W  = 16;
    localparam int NCMD  = 5120;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;

    fft1024_bfly_sequencer_if #(.LOG2N(LOG2N), .TW_W(TW_W)) bus ();

    fft1024_bfly_sequencer #(.LOG2N(LOG2N), .TW_W(TW_W)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .o_busy (busy),
        .o_done (done),
        .io_bf  (bus.master)
    );

    always #5 clk = ~clk;

    // Stand-in LUT: any injective word per index lets the bench tie twiddle to n.
    function automatic logic [31:0] lut(input logic [9:0] n);
        logic [15:0] re;
        logic [15:0] im;
        re = {6'h15, n} ^ 16'h5A5A;
        im = {n, 6'h2B} + 16'h0101;
        return {re, im};
    endfunction

    assign bus.twiddle = lut(bus.tw_addr);

    function automatic logic [63:0] cmd_word(input logic [9:0] a, input logic [9:0] b,
                                             input logic [31:0] tw, input logic [3:0] st,
                                             input logic lis, input logic last);
        return {6'b0, a, b, tw, st, lis, last};
    endfunction

    function automatic logic [63:0] obs_cmd();
        return cmd_word(bus.bf_addr_a, bus.bf_addr_b, bus.bf_twiddle, bus.bf_stage,
                        bus.bf_last_in_stage, bus.bf_last);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [9:0]  exp_a   [NCMD];
    logic [9:0]  exp_b   [NCMD];
    logic [9:0]  exp_n   [NCMD];
    logic [3:0]  exp_s   [NCMD];
    logic        exp_lis [NCMD];
    logic        exp_last[NCMD];
    logic [9:0]  got_a   [NCMD];
    logic [9:0]  got_b   [NCMD];
    logic [31:0] got_tw  [NCMD];
    logic [3:0]  got_s   [NCMD];

    task automatic check_all_zero(input string tag);
        check({tag, ":busy"}, 64'(busy), 64'(0));
        check({tag, ":done"}, 64'(done), 64'(0));
        check({tag, ":valid"}, 64'(bus.bf_valid), 64'(0));
        check({tag, ":cmd"}, obs_cmd(), 64'(0));
        check({tag, ":tw_addr"}, 64'(bus.tw_addr), 64'(0));
    endtask

    // mode 0: bf_ready high; 1: random bf_ready; 2: bf_ready low for 20 cycles on the last command.
    task automatic run_xfer(input string name, input int mode, input int start_at,
                            input bit start_on_exit, input bit record);
        int          idx;
        int          cyc;
        int          valid_cyc;
        int          n_lis;
        int          n_last;
        int          hold;
        int          loaded;
        bit          fin;
        bit          exp_done;
        bit          stalled;
        bit          finished;
        bit          pulsed;
        logic        rdy;
        logic [63:0] snap;
        logic [9:0]  snap_tw;
        idx = 0; cyc = 0; valid_cyc = 0; n_lis = 0; n_last = 0; hold = 0;
        fin = 0; stalled = 0; finished = 0; pulsed = 0; snap = '0; snap_tw = '0;
        while (!finished && cyc < 20000) begin
            exp_done = fin;
            fin = 0;
            check({name, ":done"}, 64'(done), 64'(exp_done));
            check({name, ":busy"}, 64'(busy), 64'(!exp_done));
            if (stalled) begin
                check({name, ":stall_hold"}, {obs_cmd()}, snap);
                check({name, ":stall_valid"}, 64'({bus.bf_valid, bus.tw_addr}), 64'({1'b1, snap_tw}));
            end
            loaded = idx + (bus.bf_valid ? 1 : 0);
            check({name, ":tw_addr"}, 64'(bus.tw_addr), 64'((loaded < NCMD) ? exp_n[loaded] : 10'd0));
            if (bus.bf_valid) valid_cyc++;
            case (mode)
                1:       rdy = 1'($urandom_range(0, 1));
                2:       rdy = (bus.bf_valid && bus.bf_last && hold < 20) ? 1'b0 : 1'b1;
                default: rdy = 1'b1;
            endcase
            if (mode == 2 && !rdy) hold++;
            bus.bf_ready = rdy;
            start = (start_at >= 0 && idx >= start_at && !pulsed);
            if (start) pulsed = 1;
            if (bus.bf_valid && rdy) begin
                if (idx < NCMD) begin
                    check({name, ":cmd"}, obs_cmd(),
                          cmd_word(exp_a[idx], exp_b[idx], lut(exp_n[idx]), exp_s[idx],
                                   exp_lis[idx], exp_last[idx]));
                    if (record) begin
                        got_a[idx]  = bus.bf_addr_a;
                        got_b[idx]  = bus.bf_addr_b;
                        got_tw[idx] = bus.bf_twiddle;
                        got_s[idx]  = bus.bf_stage;
                    end
                end else begin
                    check({name, ":extra_hs"}, 64'(idx + 1), 64'(NCMD));
                end
                n_lis  += bus.bf_last_in_stage ? 1 : 0;
                n_last += bus.bf_last ? 1 : 0;
                idx++;
                if (idx == NCMD) fin = 1;
            end
            if (start_on_exit && fin) start = 1'b1;
            stalled = bus.bf_valid && !rdy;
            snap    = obs_cmd();
            snap_tw = bus.tw_addr;
            if (exp_done) begin
                finished = 1;
            end else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start = 1'b0;
        check({name, ":finished_in_budget"}, 64'(finished), 64'(1));
        check({name, ":handshakes"}, 64'(idx), 64'(NCMD));
        check({name, ":last_in_stage_cnt"}, 64'(n_lis), 64'(10));
        check({name, ":last_cnt"}, 64'(n_last), 64'(1));
        if (mode == 0) check({name, ":valid_cycles"}, 64'(valid_cyc), 64'(NCMD));
        if (mode == 2) check({name, ":drain_hold"}, 64'(hold), 64'(20));
        @(posedge clk);
        #1;
        check({name, ":done_after"}, 64'(done), 64'(0));
        check({name, ":busy_after"}, 64'(busy), 64'(0));
        check({name, ":valid_after"}, 64'(bus.bf_valid), 64'(0));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int span;
        int i;
        for (int s = 0; s < LOG2N; s++) begin
            for (int k = 0; k < 512; k++) begin
                span        = 1 << s;
                i           = s * 512 + k;
                exp_a[i]    = 10'((k / span) * 2 * span + k % span);
                exp_b[i]    = 10'((k / span) * 2 * span + k % span + span);
                exp_n[i]    = 10'((k % span) * (512 / span));
                exp_s[i]    = 4'(s);
                exp_lis[i]  = (k == 511);
                exp_last[i] = (i == NCMD - 1);
            end
        end

        rst = 1'b1;
        start = 1'b0;
        bus.bf_ready = 1'b0;
        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_no_start:busy", 64'(busy), 64'(0));

        // Unstalled transform, recorded for hand-computed spot checks.
        pulse_start();
        run_xfer("run1", 0, -1, 1'b0, 1'b1);
        check("first:a_b", 64'({got_a[0], got_b[0]}), 64'({10'd0, 10'd1}));
        check("first:tw", 64'(got_tw[0]), 64'(lut(10'd0)));
        check("first:stage", 64'(got_s[0]), 64'(0));
        check("second:a_b", 64'({got_a[1], got_b[1]}), 64'({10'd2, 10'd3}));
        check("s1k1:a_b", 64'({got_a[513], got_b[513]}), 64'({10'd1, 10'd3}));
        check("s1k1:tw", 64'(got_tw[513]), 64'(lut(10'd256)));
        check("s2k5:a_b", 64'({got_a[1029], got_b[1029]}), 64'({10'd9, 10'd13}));
        check("s2k5:tw", 64'(got_tw[1029]), 64'(lut(10'd128)));
        check("s9k5:a_b", 64'({got_a[4613], got_b[4613]}), 64'({10'd5, 10'd517}));
        check("s9k5:tw", 64'(got_tw[4613]), 64'(lut(10'd5)));
        check("s9k5:stage", 64'(got_s[4613]), 64'(9));

        pulse_start();
        run_xfer("random_ready", 1, -1, 1'b0, 1'b0);

        pulse_start();
        run_xfer("stall_last", 2, -1, 1'b0, 1'b0);

        // Start mid stage 4 and again while DRAIN exits must both be ignored.
        pulse_start();
        run_xfer("start_ignored", 0, 4 * 512 + 100, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle during stage 3.
        bus.bf_ready = 1'b1;
        pulse_start();
        repeat (1700) @(posedge clk);
        #4;
        check("pre_reset:stage", 64'({bus.bf_valid, bus.bf_stage}), 64'({1'b1, 4'd3}));
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        repeat (3) begin
            @(posedge clk);
            #1;
            check("in_reset:done", 64'(done), 64'(0));
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset:busy", 64'(busy), 64'(0));
        check("post_reset:done", 64'(done), 64'(0));
        pulse_start();
        run_xfer("restart", 0, -1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
